pq_op_arbiter: RTL
==================

# pq_op_arbiter

Shares the single priority-queue core between `NREQ` independent requesters, e.g. the pushbutton/switch front end and an on-chip pattern generator. It picks one pending enqueue/dequeue request with round-robin arbitration and strobes the queue. It waits for the queue to finish and routes the result back to the originating requester. It sits between the requesters and the queue core, beside the seven-segment/RGB display path.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `KW`, 16: key/value word width.
- `TMO`, 255: maximum WAIT cycles before timeout.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_op`  in  NREQ  0 = enqueue, 1 = dequeue.
- `req_data`  in  NREQ*KW  enqueue word; requester i uses slice [i*KW +: KW].
- `req_ready`  out  NREQ  one-hot accept, at most one bit high per cycle.
- `rsp_valid`  out  NREQ  one-cycle completion pulse to the owner.
- `rsp_data`  out  KW  dequeued word; 0 for enqueue or error.
- `rsp_err`  out  1  qualifies `rsp_valid`: rejected (full/empty) or timed out.
- `pq_enq`, `pq_deq`  out  1  one-cycle command strobes to the queue.
- `pq_din`  out  KW  word to enqueue; valid with `pq_enq`.
- `pq_busy`, `pq_full`, `pq_empty`  in  1  queue status.
- `pq_dout`  in  KW  queue head/removed word.
- `state`  out  2  current FSM state, for status LEDs.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Waits for any `req_valid` with `pq_busy`=0.
  - Grant goes to the first valid requester at or after `rr_ptr`, wrapping modulo NREQ.
  - `req_ready[g]` is high combinationally in that cycle.
  - On that edge, latch `op`, data and `owner=g`.
- **Legality check at grant:**
  - Enqueue with `pq_full`=1, or dequeue with `pq_empty`=1, goes IDLE→RESP with `err`=1.
  - No queue strobe is issued in that case.
  - Otherwise IDLE→ISSUE.
- **ISSUE:**
  - Exactly one of `pq_enq`/`pq_deq` is high for one cycle; `pq_din` = latched data.
  - Next state is WAIT; the wait counter clears.
- **WAIT:**
  - Stays at least one cycle, so the queue has a cycle to raise `pq_busy`.
  - Exits to RESP on the first cycle with `pq_busy`=0. For a dequeue, `pq_dout` is captured on that edge.
  - If the counter reaches `TMO`, exits to RESP with `err`=1.
- **RESP:**
  - `rsp_valid[owner]`=1 for one cycle, with `rsp_data` and `rsp_err` driven from registers.
  - `rr_ptr` ← (owner+1) mod NREQ; next state IDLE.
- Requesters hold `req_valid`/`req_op`/`req_data` stable until `req_ready`. Deasserting before grant withdraws the request.
- Only one operation is in flight at a time. No request is granted outside IDLE.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, and all outputs 0 (`req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `pq_enq`, `pq_deq`, `pq_din`, `state`).
- Reset mid-operation abandons the operation silently. No response is issued, and the queue core is reset with the same `rst_n`.
- Legal op granted at cycle t:
  - ISSUE at t+1, WAIT from t+2.
  - Earliest RESP (with `rsp_valid`) at t+3 if `pq_busy`=0 at t+2.
  - Next grant no earlier than t+4.
- Rejected op granted at t: RESP at t+1, next grant at t+2.
- Timeout: RESP `TMO`+1 cycles after entering WAIT.
- `pq_full`/`pq_empty` are sampled only in the grant cycle.
- A simultaneous `req_valid` and `pq_busy`=1 in IDLE produces no grant.
- Pointer wrap: owner = NREQ-1 sets `rr_ptr` to 0.
- The same requester may be re-granted immediately if it is the only one valid.

## Structure
- Shared in `pq_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t`
  - `typedef enum logic {OP_ENQ, OP_DEQ} pq_op_t`
  - `localparam KW_DEF = 16`
- Sub-module `rr_arbiter`:
  - Parameterised by NREQ; combinational.
  - Inputs `req` and `ptr`; outputs one-hot `gnt` and binary `gnt_idx`.
- Everything else (FSM, latches, timeout counter) is in `pq_op_arbiter`.

## Test plan
- **Single enqueue:** NREQ=2, req0 enq 16'h00A5, queue idle and empty.
  - `req_ready`=2'b01 at t, `pq_enq` with `pq_din`=16'h00A5 at t+1.
  - `rsp_valid`=2'b01 with `rsp_err`=0 after `pq_busy` falls.
- **Fairness:** req0 and req1 both enq, held continuously, 4 operations.
  - Grant order 0,1,0,1; every `rsp_valid` goes to the matching owner.
- **Empty dequeue:** req1 deq with `pq_empty`=1.
  - No `pq_deq` strobe; `rsp_valid`=2'b10 and `rsp_err`=1 one cycle after grant.
- **Dequeue result:** after enqueues of 16'h0030 and 16'h0010, req0 deq with `pq_dout`=16'h0010.
  - `rsp_data`=16'h0010, `rsp_err`=0.
- **Timeout:** hold `pq_busy`=1 after an issue.
  - `rsp_err`=1 exactly TMO+1 cycles after WAIT entry; then back to IDLE.
- **Reset mid-WAIT:** pulse `rst_n` low in WAIT.
  - All outputs 0 immediately; `state`=IDLE; no `rsp_valid`; next grant goes to req0.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue front end: arbiter FSM states and
// queue operation codes.
package pq_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic {OP_ENQ, OP_DEQ} pq_op_t;
  localparam int KW_DEF = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Produces both one-hot and binary forms of the grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);
  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/pq_op_arbiter.sv
// Shares one priority-queue core between NREQ requesters: grants one request
// round-robin, strobes the queue, waits for completion and returns the result.
module pq_op_arbiter
  import pq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int KW   = KW_DEF,
  parameter int TMO  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*KW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [KW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              pq_enq,
  output logic              pq_deq,
  output logic [KW-1:0]     pq_din,
  input  logic              pq_busy,
  input  logic              pq_full,
  input  logic              pq_empty,
  input  logic [KW-1:0]     pq_dout,
  output logic [1:0]        state
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  pq_op_t        op_q, op_d;
  logic [KW-1:0] data_q, data_d;
  logic [KW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            grant_ok;
  logic            gnt_op;
  logic [KW-1:0]   gnt_data;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant_ok = (state_q == ARB_IDLE) && !pq_busy && (|req_valid);
  assign gnt_op   = req_op[gnt_idx];
  assign gnt_data = req_data[int'(gnt_idx)*KW +: KW];
  // Gated with rst_n so nothing is accepted while the block is held in reset.
  assign req_ready = (grant_ok && rst_n) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_ok) begin
          owner_d = gnt_idx;
          op_d    = pq_op_t'(gnt_op);
          data_d  = gnt_data;
          rdata_d = '0;
          if ((gnt_op == OP_ENQ && pq_full) || (gnt_op == OP_DEQ && pq_empty)) begin
            err_d   = 1'b1;
            state_d = ARB_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (!pq_busy) begin
          if (op_q == OP_DEQ) rdata_d = pq_dout;
          state_d = ARB_RESP;
        end else if (cnt_q == CW'(TMO)) begin
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RESP: begin
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        // Result registers only carry data during the response cycle.
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= OP_ENQ;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = (state_q == ARB_RESP) && (owner_q == IW'(gi));
  end

  assign rsp_data = rdata_q;
  assign rsp_err  = err_q;
  assign pq_enq   = (state_q == ARB_ISSUE) && (op_q == OP_ENQ);
  assign pq_deq   = (state_q == ARB_ISSUE) && (op_q == OP_DEQ);
  assign pq_din   = data_q;
  assign state    = state_q;
endmodule
